// File: rtl/fwft_word_serializer.sv
// Pops wide words from a first-word-fall-through FIFO and streams each one out as
// IN_WIDTH/OUT_WIDTH narrow slices on a valid/ready port. Define SERIALIZER_MSB_FIRST_EN
// to emit the most significant slice first; by default the least significant slice goes first.
module fwft_word_serializer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
    localparam int CNT_WIDTH = $clog2(RATIO) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 fifo_pop,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic [31:0]          word_count
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(RATIO - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IN_WIDTH-1:0]    r_shift;
    logic [CNT_WIDTH-1:0]   r_slice_idx;
    logic [31:0]            r_word_count;

    logic                   w_hold;
    logic                   w_at_last;
    logic                   w_accept;
    logic                   w_last_acc;
    logic                   w_pop;
    logic [OUT_WIDTH-1:0]   w_slice0;
    logic [IN_WIDTH-1:0]    w_shift_adv;

    assign w_hold     = (r_state == S_HOLD);
    assign w_at_last  = (r_slice_idx == LAST_IDX);
    assign w_accept   = w_hold && m_ready;
    assign w_last_acc = w_accept && w_at_last;
    // A pop may coincide with the final accept so consecutive words stream without a bubble.
    assign w_pop      = !reset && !fifo_empty && (!w_hold || w_last_acc);

`ifdef SERIALIZER_MSB_FIRST_EN
    assign w_slice0    = r_shift[IN_WIDTH-1 -: OUT_WIDTH];
    assign w_shift_adv = r_shift << OUT_WIDTH;
`else
    assign w_slice0    = r_shift[OUT_WIDTH-1:0];
    assign w_shift_adv = r_shift >> OUT_WIDTH;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_pop) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_last_acc && !w_pop) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        fifo_pop = w_pop;
        m_valid  = w_hold;
        m_last   = w_hold && w_at_last;
        m_data   = w_hold ? w_slice0 : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_slice_idx  <= '0;
            r_word_count <= '0;
        end else begin
            if (w_pop) begin
                r_shift     <= fifo_data;
                r_slice_idx <= '0;
            end else if (w_accept) begin
                r_shift     <= w_shift_adv;
                r_slice_idx <= w_last_acc ? '0 : r_slice_idx + 1'b1;
            end
            if (w_last_acc) begin
                r_word_count <= r_word_count + 32'd1;
            end
        end
    end

    assign word_count = r_word_count;

endmodule

// File: tb/tb_fwft_word_serializer.sv
// Directed bench for fwft_word_serializer: a queue-based FWFT FIFO model feeds the DUT
// and a slice scoreboard, filled when words are queued, checks every accepted slice.
module tb_fwft_word_serializer;

    localparam int IN_W  = 64;
    localparam int OUT_W = 16;
    localparam int RATIO = IN_W / OUT_W;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } slice_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              fifo_empty;
    logic [IN_W-1:0]   fifo_data;
    logic              fifo_pop;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic              m_last;
    logic [31:0]       word_count;

    logic [IN_W-1:0]   fifo_q[$];
    slice_t            sb_q[$];
    int                pop_log[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                cur_run = 0;
    int                max_run = 0;
    int                acc_cnt = 0;
    logic [31:0]       exp_wc  = '0;
    logic              prev_stall = 1'b0;
    logic [OUT_W-1:0]  prev_data  = '0;
    logic              prev_last  = 1'b0;

    always #5 clk = ~clk;

    fwft_word_serializer #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .word_count (word_count)
    );

    // FIFO model: the head word leaves on the edge where the DUT pops it.
    always @(posedge clk) begin
        if (fifo_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [IN_W-1:0] w);
        slice_t s;
        fifo_q.push_back(w);
        for (int k = 0; k < RATIO; k++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
            s.data = w[IN_W-1-k*OUT_W -: OUT_W];
`else
            s.data = w[k*OUT_W +: OUT_W];
`endif
            s.last = (k == RATIO - 1);
            sb_q.push_back(s);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later.
    task automatic step(input logic rdy, input logic rst);
        slice_t e;
        @(negedge clk);
        reset      = rst;
        m_ready    = rdy;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
        #1;
        cyc++;
        if (rst) begin
            exp_wc     = '0;
            prev_stall = 1'b0;
            check("rst_pop",   64'(fifo_pop), 64'(0));
            check("rst_valid", 64'(m_valid),  64'(0));
            check("rst_data",  64'(m_data),   64'(0));
            check("rst_last",  64'(m_last),   64'(0));
        end
        check("word_count", 64'(word_count), 64'(exp_wc));
        if (fifo_pop) begin
            pop_log.push_back(cyc);
            check("pop_when_empty", 64'(fifo_empty), 64'(0));
        end
        if (prev_stall) begin
            check("stall_valid", 64'(m_valid), 64'(1));
            check("stall_data",  64'(m_data),  64'(prev_data));
            check("stall_last",  64'(m_last),  64'(prev_last));
        end
        cur_run = m_valid ? cur_run + 1 : 0;
        if (cur_run > max_run) max_run = cur_run;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("slice_data", 64'(m_data), 64'(e.data));
                check("slice_last", 64'(m_last), 64'(e.last));
                acc_cnt++;
                if (e.last) exp_wc = exp_wc + 32'd1;
            end
        end
    endtask

    task automatic drain(input int budget, input logic [3:0] pat);
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < budget) begin
            step(pat[i % 4], 1'b0);
            i++;
        end
        check("drain_done", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        reset      = 1'b0;
        m_ready    = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        #2 reset   = 1'b1;

        // Reset with a word already waiting in the FIFO
        push_word(64'h0004_0003_0002_0001);
        repeat (3) step(1'b1, 1'b1);
        check("t1_fifo_kept", 64'(fifo_q.size()), 64'(1));

        // Single word, ready always high
        pop_log.delete();
        max_run = 0;
        drain(20, 4'b1111);
        repeat (2) step(1'b1, 1'b0);
        check("t2_pops",  64'(pop_log.size()), 64'(1));
        check("t2_run",   64'(max_run), 64'(4));
        check("t2_count", 64'(word_count), 64'(1));
        $display("[TB] single word: %0d pops, run %0d, word_count %0d", pop_log.size(), max_run, word_count);

        // Three queued words stream back to back
        pop_log.delete();
        max_run = 0;
        push_word(64'h1111_2222_3333_4444);
        push_word(64'hdead_beef_0123_4567);
        push_word(64'h8000_0000_0000_0001);
        drain(40, 4'b1111);
        repeat (2) step(1'b1, 1'b0);
        check("t3_pops", 64'(pop_log.size()), 64'(3));
        if (pop_log.size() == 3) begin
            check("t3_gap1", 64'(pop_log[1] - pop_log[0]), 64'(4));
            check("t3_gap2", 64'(pop_log[2] - pop_log[0]), 64'(8));
        end
        check("t3_run",   64'(max_run), 64'(12));
        check("t3_count", 64'(word_count), 64'(4));
        $display("[TB] three words: %0d pops, run %0d, word_count %0d", pop_log.size(), max_run, word_count);

        // Backpressure with ready pattern 1,0,0,1
        acc_cnt = 0;
        push_word(64'h0004_0003_0002_0001);
        drain(60, 4'b1001);
        repeat (2) step(1'b1, 1'b0);
        check("t4_accepts", 64'(acc_cnt), 64'(4));
        check("t4_count",   64'(word_count), 64'(5));
        $display("[TB] backpressure: %0d slices accepted, word_count %0d", acc_cnt, word_count);

        // Reset in the middle of a word, with the next word already queued
        acc_cnt = 0;
        push_word(64'h0aaa_0bbb_0ccc_0ddd);
        for (int i = 0; i < 10 && acc_cnt < 2; i++) step(1'b1, 1'b0);
        check("t5_pre_accepts", 64'(acc_cnt), 64'(2));
        push_word(64'h0044_0033_0022_0011);
        step(1'b1, 1'b1);
        for (int k = 0; k < RATIO - 2; k++) void'(sb_q.pop_front());
        check("t5_fifo_kept", 64'(fifo_q.size()), 64'(1));
        acc_cnt = 0;
        drain(20, 4'b1111);
        repeat (2) step(1'b1, 1'b0);
        check("t5_accepts", 64'(acc_cnt), 64'(4));
        check("t5_count",   64'(word_count), 64'(1));
        $display("[TB] mid-word reset: %0d slices after release, word_count %0d", acc_cnt, word_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
